// File: rtl/ahblite_mmio_wait_bridge.sv
// AHB-Lite slave to MMIO master bridge with wait states, window/size/alignment errors.
// Optional response timeout when AHBLITE_MMIO_TIMEOUT_EN is defined.
module ahblite_mmio_wait_bridge #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] WIN_SIZE       = ADDR_WIDTH'('h1000),
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_byteen,
  input  logic                    wr_ready,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_valid
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(BeWidth);
  localparam logic [ADDR_WIDTH-1:0] WinMask = ~(WIN_SIZE - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StErr1, StErr2} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BeWidth-1:0]      be_q, be_d;

  logic                    accept, good, done, timeout;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic [BeWidth-1:0]      lane_base, lanes;

  logic unused_sig;
  assign unused_sig = htrans[0];

  assign accept     = hsel & htrans[1] & hready;
  assign align_mask = ~({ADDR_WIDTH{1'b1}} << hsize);
  assign good       = ((haddr & WinMask) == BASE_ADDR) &&
                      (hsize <= 3'(LaneBits)) &&
                      ((haddr & align_mask) == '0);
  assign lane_base  = BeWidth'((32'd1 << (32'd1 << hsize)) - 32'd1);
  assign lanes      = lane_base << haddr[LaneBits-1:0];

  // A data phase completes (and may accept the next address phase) in these cases.
  always_comb begin
    done = 1'b0;
    case (state_q)
      StIdle:  done = 1'b1;
      StWrite: done = wr_ready;
      StRead:  done = rd_valid;
      StErr2:  done = 1'b1;
      default: done = 1'b0;
    endcase
  end

`ifdef AHBLITE_MMIO_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES);
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                busy;

  assign busy    = (state_q == StWrite) || (state_q == StRead);
  assign timeout = busy && !done && (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = (busy && !done && !timeout) ? cnt_q + CntWidth'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if (done) begin
      state_d = StIdle;
      if (accept) begin
        if (!good) begin
          state_d = StErr1;
        end else begin
          state_d = hwrite ? StWrite : StRead;
          addr_d  = haddr;
          be_d    = lanes;
        end
      end
    end else if (timeout) begin
      state_d = StErr1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  // Requests are gated by rst so a pending access drops in the cycle reset is sampled.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state_q)
      StWrite: begin
        wr_en     = ~rst;
        hreadyout = wr_ready;
      end
      StRead: begin
        rd_en     = ~rst;
        hreadyout = rd_valid;
        hrdata    = rd_data;
      end
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      StErr2: begin
        hresp     = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_addr   = addr_q;
  assign rd_addr   = addr_q;
  assign wr_byteen = be_q;
  assign wr_data   = hwdata;

endmodule

// File: doc/ahblite_mmio_wait_bridge.md
# ahblite_mmio_wait_bridge

AHB-Lite slave to MMIO master bridge with wait-state and error-response support. Sits between the AHB-Lite interconnect and register/memory blocks whose read data and write acceptance may take a variable number of cycles. Adds address-window decoding, size/alignment checking and an optional response timeout. Replaces the zero-wait, always-OKAY bridge for slaves that cannot answer in one cycle.

## Interface

- ADDR_WIDTH, 32, AHB/MMIO address width
- DATA_WIDTH, 32, data width; 32 or 64
- BASE_ADDR, 'h0, first byte address of the decoded window
- WIN_SIZE, 'h1000, window size in bytes; power of two, BASE_ADDR aligned to it
- TIMEOUT_CYCLES, 256, data-phase cycles before timeout error; ≥2

- clk  in  1  bridge clock, shared by AHB and MMIO sides
- rst  in  1  reset; synchronous, active-high
- hsel  in  1  AHB slave select
- haddr  in  ADDR_WIDTH  AHB address
- htrans  in  2  AHB transfer type
- hwrite  in  1  1 = write
- hsize  in  3  AHB transfer size
- hwdata  in  DATA_WIDTH  write data, data phase
- hready  in  1  global HREADY
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data
- wr_en  out  1  MMIO write request, held until accepted
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- wr_byteen  out  DATA_WIDTH/8  write byte lanes
- wr_ready  in  1  MMIO write accepted this cycle
- rd_en  out  1  MMIO read request, held until valid
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  DATA_WIDTH  read data, valid with rd_valid
- rd_valid  in  1  MMIO read data valid this cycle

## Operation

- Address phase accepted when hsel & htrans[1] & hready. IDLE/BUSY, or hsel=0: no MMIO access, zero-wait OKAY.
- Accepted phase is checked; failing any check → ERROR, no MMIO access:
  - haddr outside [BASE_ADDR, BASE_ADDR+WIN_SIZE)
  - hsize > log2(DATA_WIDTH/8)
  - haddr not aligned to 2^hsize
- Otherwise haddr and hwrite are registered; byte lanes = ((1<<(1<<hsize))-1) << haddr[log2(DATA_WIDTH/8)-1:0].
- States: IDLE, WRITE, READ, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. Accepted good write → WRITE; good read → READ; bad → ERR1.
  - WRITE: wr_en=1, wr_addr/wr_byteen registered, wr_data=hwdata; hreadyout=wr_ready. On wr_ready, complete.
  - READ: rd_en=1, rd_addr registered; hrdata=rd_data, hreadyout=rd_valid. On rd_valid, complete.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1; completes.
- On completion, a transfer accepted in the same cycle enters its state directly (back-to-back, no bubble); else → IDLE.
- hrdata = 0 outside READ.
- wr_en/rd_en never both high. Address/byteen stable while the request is pending.

## Timing

- Reset: state IDLE, hreadyout=1, hresp=0, wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, wr_byteen=0, hrdata=0, timeout counter 0.
- Request asserted in the first data-phase cycle (one after the address phase).
- Fastest access: wr_ready/rd_valid high in the first data-phase cycle → zero-wait, one-cycle data phase.
- Each extra cycle of wr_ready/rd_valid low adds one AHB wait state.
- Error response: exactly two cycles, ERR1 then ERR2. An address phase presented during ERR1 is not accepted (hready low). The master may change htrans to IDLE during ERR1 (AHB-Lite cancel).
- rd_valid/wr_ready outside the matching state: ignored.
- rst during a pending access: request dropped in the same cycle it is sampled; no response to the interrupted AHB transfer.

## Configuration

- AHBLITE_MMIO_TIMEOUT_EN defined:
  - Counter runs in WRITE/READ and clears on entry.
  - If wr_ready/rd_valid is still low in data-phase cycle TIMEOUT_CYCLES, the request drops the next cycle and the state goes to ERR1.
  - A late rd_valid/wr_ready after the timeout is ignored.
- Not defined: no counter; the bridge waits indefinitely; TIMEOUT_CYCLES is unused.

## Test plan

- Word write 0xDEADBEEF to BASE_ADDR+4, wr_ready tied high → wr_en one cycle, wr_byteen=4'b1111, OKAY, zero wait.
- Byte write to BASE_ADDR+3 with hsize=0 → wr_byteen=4'b1000; halfword to +2 → 4'b1100.
- Read with rd_valid delayed 3 cycles, rd_data=0x12345678 → 3 wait states, rd_en held 4 cycles, hrdata=0x12345678.
- Address BASE_ADDR+WIN_SIZE, and halfword at +1 → each gives two-cycle ERROR (hreadyout 0 then 1), no wr_en/rd_en.
- Back-to-back write→read→write with zero-wait slave → three consecutive one-cycle data phases, no bubbles.
- With AHBLITE_MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=4, rd_valid never asserted → rd_en high 4 cycles, then ERROR; reset mid-wait → all outputs at reset values next cycle.
